snake_body_streamer: RTL and testbench

//  Owns the snake's segment coordinates and sends them to the graphic wrapper, which reads them.

---
 rtl/snake_body_streamer_pkg.sv | 44 ++++
 rtl/snake_body_streamer_if.sv | 14 +
 rtl/snake_body_streamer_next_head.sv | 63 ++++++
 rtl/snake_body_streamer.sv | 182 ++++++++++++++++++
 tb/tb_snake_body_streamer.sv | 385 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snake_body_streamer_pkg.sv
// Shared parameters, encodings and types for the snake body streamer.
// Optional feature macro: SNAKE_WRAP_EN (head wraps at grid edges instead of wall collision).
`ifndef PIXEL_DISPLAY_BIT
`define PIXEL_DISPLAY_BIT 9
`endif

package snake_body_streamer_pkg;

    localparam int unsigned MAX_LEN     = 15;
    localparam int unsigned COORD_W     = 7;
    localparam int unsigned GRID_W      = 80;
    localparam int unsigned GRID_H      = 60;
    localparam int unsigned START_X     = 40;
    localparam int unsigned START_Y     = 30;
    localparam int unsigned START_LEN   = 2;
    localparam int unsigned STREAM_LINE = 480;
    localparam int unsigned PIX_W       = `PIXEL_DISPLAY_BIT + 1;
    localparam int unsigned LEN_W       = 4;
    localparam int unsigned DIR_W       = 2;

    localparam logic [DIR_W-1:0] DIR_RIGHT = 2'b00;
    localparam logic [DIR_W-1:0] DIR_LEFT  = 2'b01;
    localparam logic [DIR_W-1:0] DIR_UP    = 2'b10;
    localparam logic [DIR_W-1:0] DIR_DOWN  = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;
    localparam logic [1:0] ST_SHIFT  = 2'd3;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } coord_t;

    // Start-of-game position of segment i: a horizontal line ending at the head.
    function automatic coord_t start_seg(input int unsigned i);
        coord_t c;
        c.x = COORD_W'(START_X - i);
        c.y = COORD_W'(START_Y);
        return c;
    endfunction

endpackage

// File: rtl/snake_body_streamer_if.sv
// Body-segment stream from the snake store to the graphic wrapper.
interface snake_body_streamer_if;
    import snake_body_streamer_pkg::*;

    logic [COORD_W-1:0] snake_body_x;
    logic [COORD_W-1:0] snake_body_y;
    logic               en_snake_body;
    logic [LEN_W-1:0]   snake_length;

    modport master (output snake_body_x, output snake_body_y,
                    output en_snake_body, output snake_length);
    modport slave  (input  snake_body_x, input  snake_body_y,
                    input  en_snake_body, input  snake_length);
endinterface

// File: rtl/snake_body_streamer_next_head.sv
// Combinational one-block head step; edge handling depends on SNAKE_WRAP_EN.
module snake_body_streamer_next_head
    import snake_body_streamer_pkg::*;
(
    input  coord_t           head_i,
    input  logic [DIR_W-1:0] dir_i,
    output coord_t           next_c,
    output logic             wall_hit_c
);

    // Step the head one block, wrapping or flagging a wall hit at the grid edge.
    always_comb begin
        next_c     = head_i;
        wall_hit_c = 1'b0;
        case (dir_i)
            DIR_RIGHT: begin
                if (head_i.x == COORD_W'(GRID_W - 1)) begin
`ifdef SNAKE_WRAP_EN
                    next_c.x = '0;
`else
                    wall_hit_c = 1'b1;
`endif
                end else begin
                    next_c.x = head_i.x + COORD_W'(1);
                end
            end
            DIR_LEFT: begin
                if (head_i.x == '0) begin
`ifdef SNAKE_WRAP_EN
                    next_c.x = COORD_W'(GRID_W - 1);
`else
                    wall_hit_c = 1'b1;
`endif
                end else begin
                    next_c.x = head_i.x - COORD_W'(1);
                end
            end
            DIR_UP: begin
                if (head_i.y == '0) begin
`ifdef SNAKE_WRAP_EN
                    next_c.y = COORD_W'(GRID_H - 1);
`else
                    wall_hit_c = 1'b1;
`endif
                end else begin
                    next_c.y = head_i.y - COORD_W'(1);
                end
            end
            default: begin
                if (head_i.y == COORD_W'(GRID_H - 1)) begin
`ifdef SNAKE_WRAP_EN
                    next_c.y = '0;
`else
                    wall_hit_c = 1'b1;
`endif
                end else begin
                    next_c.y = head_i.y + COORD_W'(1);
                end
            end
        endcase
    end

endmodule

// File: rtl/snake_body_streamer.sv
// Snake segment store: move/collision sequencing and once-per-frame body streaming.
// Optional feature macro: SNAKE_WRAP_EN (wrap at grid edges; wall_collision stays 0).
module snake_body_streamer
    import snake_body_streamer_pkg::*;
(
    input  logic                clock_25,
    input  logic                reset,
    input  logic [PIX_W-1:0]    X,
    input  logic [PIX_W-1:0]    Y,
    input  logic                move_tick,
    input  logic [DIR_W-1:0]    direction,
    input  logic                grow,
    input  logic                game_restart,
    output logic [COORD_W-1:0]  snake_head_x,
    output logic [COORD_W-1:0]  snake_head_y,
    output logic                self_collision,
    output logic                wall_collision,
    snake_body_streamer_if.master body_if
);

    logic [1:0]       state_q, state_d;
    coord_t           seg_q [MAX_LEN];
    coord_t           seg_d [MAX_LEN];
    logic [LEN_W-1:0] length_q, length_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [DIR_W-1:0] cur_dir_q, cur_dir_d;
    logic             frozen_q, frozen_d;
    logic             pending_q, pending_d;
    logic             pend_grow_q, pend_grow_d;
    logic             chk_grow_q, chk_grow_d;
    logic             en_q, en_d;
    coord_t           body_q, body_d;
    logic             self_col_q, self_col_d;
    logic             wall_col_q, wall_col_d;

    coord_t           next_head_c;
    logic             wall_hit_c;
    logic             stream_trig_c;
    logic             tail_skip_c;
    logic             hit_c;

    snake_body_streamer_next_head u_next_head (
        .head_i     (seg_q[0]),
        .dir_i      (cur_dir_q),
        .next_c     (next_head_c),
        .wall_hit_c (wall_hit_c)
    );

    assign stream_trig_c = (X == PIX_W'(0)) && (Y == PIX_W'(STREAM_LINE));
    // Without growth the tail moves away this step, so it cannot be hit.
    assign tail_skip_c   = !chk_grow_q && (idx_q == length_q - LEN_W'(1));
    assign hit_c         = !tail_skip_c && (seg_q[idx_q] == next_head_c);

    // State and datapath registers.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            for (int unsigned i = 0; i < MAX_LEN; i++) seg_q[i] <= start_seg(i);
            length_q    <= LEN_W'(START_LEN);
            idx_q       <= '0;
            cur_dir_q   <= DIR_RIGHT;
            frozen_q    <= 1'b0;
            pending_q   <= 1'b0;
            pend_grow_q <= 1'b0;
            chk_grow_q  <= 1'b0;
            en_q        <= 1'b0;
            body_q      <= '0;
            self_col_q  <= 1'b0;
            wall_col_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            seg_q       <= seg_d;
            length_q    <= length_d;
            idx_q       <= idx_d;
            cur_dir_q   <= cur_dir_d;
            frozen_q    <= frozen_d;
            pending_q   <= pending_d;
            pend_grow_q <= pend_grow_d;
            chk_grow_q  <= chk_grow_d;
            en_q        <= en_d;
            body_q      <= body_d;
            self_col_q  <= self_col_d;
            wall_col_q  <= wall_col_d;
        end
    end

    // Next-state and datapath updates: tick latch, stream, check, shift, restart.
    always_comb begin
        state_d     = state_q;
        seg_d       = seg_q;
        length_d    = length_q;
        idx_d       = idx_q;
        cur_dir_d   = cur_dir_q;
        frozen_d    = frozen_q;
        pending_d   = pending_q;
        pend_grow_d = pend_grow_q;
        chk_grow_d  = chk_grow_q;
        en_d        = 1'b0;
        body_d      = body_q;
        self_col_d  = 1'b0;
        wall_col_d  = 1'b0;

        if (move_tick && !pending_q) begin
            pending_d   = 1'b1;
            pend_grow_d = grow;
        end

        case (state_q)
            ST_IDLE: begin
                if (stream_trig_c) begin
                    state_d = ST_STREAM;
                    en_d    = 1'b1;
                    body_d  = seg_q[1];
                    idx_d   = LEN_W'(2);
                end else if (pending_q && !frozen_q) begin
                    state_d     = ST_CHECK;
                    idx_d       = LEN_W'(1);
                    chk_grow_d  = pend_grow_q;
                    pending_d   = move_tick;
                    pend_grow_d = grow;
                    if ((direction ^ DIR_LEFT) != cur_dir_q) cur_dir_d = direction;
                end
            end
            ST_STREAM: begin
                if (idx_q == length_q) begin
                    state_d = ST_IDLE;
                end else begin
                    en_d   = 1'b1;
                    body_d = seg_q[idx_q];
                    idx_d  = idx_q + LEN_W'(1);
                end
            end
            ST_CHECK: begin
                if (wall_hit_c) begin
                    wall_col_d = 1'b1;
                    frozen_d   = 1'b1;
                    state_d    = ST_IDLE;
                end else if (hit_c) begin
                    self_col_d = 1'b1;
                    frozen_d   = 1'b1;
                    state_d    = ST_IDLE;
                end else if (idx_q == length_q - LEN_W'(1)) begin
                    state_d = ST_SHIFT;
                end else begin
                    idx_d = idx_q + LEN_W'(1);
                end
            end
            default: begin
                for (int unsigned i = 1; i < MAX_LEN; i++) seg_d[i] = seg_q[i-1];
                seg_d[0] = next_head_c;
                if (chk_grow_q && (length_q != LEN_W'(MAX_LEN))) length_d = length_q + LEN_W'(1);
                state_d = ST_IDLE;
            end
        endcase

        if (game_restart) begin
            state_d     = ST_IDLE;
            for (int unsigned i = 0; i < MAX_LEN; i++) seg_d[i] = start_seg(i);
            length_d    = LEN_W'(START_LEN);
            idx_d       = '0;
            cur_dir_d   = DIR_RIGHT;
            frozen_d    = 1'b0;
            pending_d   = 1'b0;
            pend_grow_d = 1'b0;
            chk_grow_d  = 1'b0;
            en_d        = 1'b0;
            body_d      = '0;
            self_col_d  = 1'b0;
            wall_col_d  = 1'b0;
        end
    end

    assign snake_head_x          = seg_q[0].x;
    assign snake_head_y          = seg_q[0].y;
    assign self_collision        = self_col_q;
    assign wall_collision        = wall_col_q;
    assign body_if.snake_body_x  = body_q.x;
    assign body_if.snake_body_y  = body_q.y;
    assign body_if.en_snake_body = en_q;
    assign body_if.snake_length  = length_q;

endmodule

// File: tb/tb_snake_body_streamer.sv
// Self-checking bench for snake_body_streamer: reference snake model + body-beat scoreboard.
module tb_snake_body_streamer;
    import snake_body_streamer_pkg::*;

    logic               clk;
    logic               rst_n;
    logic [PIX_W-1:0]   X, Y;
    logic               move_tick, grow, game_restart;
    logic [DIR_W-1:0]   direction;
    logic [COORD_W-1:0] snake_head_x, snake_head_y;
    logic               self_collision, wall_collision;

    snake_body_streamer_if body_if ();

    snake_body_streamer dut (
        .clock_25       (clk),
        .reset          (rst_n),
        .X              (X),
        .Y              (Y),
        .move_tick      (move_tick),
        .direction      (direction),
        .grow           (grow),
        .game_restart   (game_restart),
        .snake_head_x   (snake_head_x),
        .snake_head_y   (snake_head_y),
        .self_collision (self_collision),
        .wall_collision (wall_collision),
        .body_if        (body_if)
    );

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int self_seen = 0;
    int wall_seen = 0;

    // Reference model of the snake.
    int         m_x [MAX_LEN];
    int         m_y [MAX_LEN];
    int         m_len;
    logic [1:0] m_dir;
    bit         m_frozen;
    int         exp_self = 0;
    int         exp_wall = 0;

    logic [2*COORD_W-1:0] exp_q [$];

    task automatic model_reset();
        for (int i = 0; i < MAX_LEN; i++) begin
            m_x[i] = int'(START_X) - i;
            m_y[i] = int'(START_Y);
        end
        m_len    = int'(START_LEN);
        m_dir    = 2'b00;
        m_frozen = 1'b0;
    endtask

    task automatic model_tick(input logic [1:0] d, input bit g);
        int nx, ny, last;
        bit wall, hit;
        if (m_frozen) return;
        if (!((d == 2'b00 && m_dir == 2'b01) || (d == 2'b01 && m_dir == 2'b00) ||
              (d == 2'b10 && m_dir == 2'b11) || (d == 2'b11 && m_dir == 2'b10)))
            m_dir = d;
        nx = m_x[0];
        ny = m_y[0];
        case (m_dir)
            2'b00:   nx = nx + 1;
            2'b01:   nx = nx - 1;
            2'b10:   ny = ny - 1;
            default: ny = ny + 1;
        endcase
        wall = 1'b0;
`ifdef SNAKE_WRAP_EN
        nx = (nx + 80) % 80;
        ny = (ny + 60) % 60;
`else
        if (nx < 0 || nx > 79 || ny < 0 || ny > 59) wall = 1'b1;
`endif
        if (wall) begin
            m_frozen = 1'b1;
            exp_wall++;
            return;
        end
        last = g ? m_len : m_len - 1;
        hit  = 1'b0;
        for (int i = 1; i < last; i++)
            if (m_x[i] == nx && m_y[i] == ny) hit = 1'b1;
        if (hit) begin
            m_frozen = 1'b1;
            exp_self++;
            return;
        end
        for (int i = MAX_LEN - 1; i > 0; i--) begin
            m_x[i] = m_x[i-1];
            m_y[i] = m_y[i-1];
        end
        m_x[0] = nx;
        m_y[0] = ny;
        if (g && m_len < 15) m_len++;
    endtask

    task automatic push_stream_expect();
        for (int i = 1; i < m_len; i++)
            exp_q.push_back({COORD_W'(m_x[i]), COORD_W'(m_y[i])});
    endtask

    // Scoreboard: every body beat must match the next expected segment.
    always @(negedge clk) begin
        logic [2*COORD_W-1:0] e;
        if (body_if.en_snake_body === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL body_beat got (%0d,%0d) expected no beat",
                         body_if.snake_body_x, body_if.snake_body_y);
            end else begin
                e = exp_q.pop_front();
                if ({body_if.snake_body_x, body_if.snake_body_y} !== e) begin
                    n_fail++;
                    $display("FAIL body_beat got (%0d,%0d) expected (%0d,%0d)",
                             body_if.snake_body_x, body_if.snake_body_y,
                             e[2*COORD_W-1:COORD_W], e[COORD_W-1:0]);
                end
            end
        end
        if (self_collision === 1'b1) self_seen++;
        if (wall_collision === 1'b1) wall_seen++;
    end

    task automatic do_tick(input logic [1:0] d, input bit g);
        @(negedge clk);
        direction = d;
        grow      = g;
        move_tick = 1'b1;
        model_tick(d, g);
        @(negedge clk);
        move_tick = 1'b0;
        grow      = 1'b0;
        repeat (MAX_LEN + 4) @(negedge clk);
    endtask

    // Drives the frame trigger for one cycle; returns on the first-beat sample point.
    task automatic trigger_stream();
        @(negedge clk);
        push_stream_expect();
        X = '0;
        Y = PIX_W'(STREAM_LINE);
        @(negedge clk);
        X = PIX_W'(1);
        Y = '0;
    endtask

    task automatic do_restart();
        @(negedge clk);
        game_restart = 1'b1;
        @(negedge clk);
        game_restart = 1'b0;
        exp_q.delete();
        model_reset();
    endtask

    task automatic test_reset();
        n_tests++;
        if (snake_head_x !== 7'd40 || snake_head_y !== 7'd30) begin
            n_fail++;
            $display("FAIL reset_head got (%0d,%0d) expected (40,30)", snake_head_x, snake_head_y);
        end
        n_tests++;
        if (body_if.snake_length !== 4'd2) begin
            n_fail++;
            $display("FAIL reset_length got %0d expected 2", body_if.snake_length);
        end
        n_tests++;
        if ({body_if.en_snake_body, self_collision, wall_collision} !== 3'b000 ||
            body_if.snake_body_x !== 7'd0 || body_if.snake_body_y !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got en=%b sc=%b wc=%b body=(%0d,%0d) expected zeros",
                     body_if.en_snake_body, self_collision, wall_collision,
                     body_if.snake_body_x, body_if.snake_body_y);
        end
    endtask

    task automatic test_first_stream();
        trigger_stream();
        n_tests++;
        if (body_if.en_snake_body !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_first_beat got en=%b expected 1", body_if.en_snake_body);
        end
        repeat (4) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stream_beats_left got %0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_grow_up();
        do_tick(DIR_UP, 1'b1);
        n_tests++;
        if (snake_head_x !== 7'd40 || snake_head_y !== 7'd29 || body_if.snake_length !== 4'd3) begin
            n_fail++;
            $display("FAIL grow_up got (%0d,%0d) len %0d expected (40,29) len 3",
                     snake_head_x, snake_head_y, body_if.snake_length);
        end
        trigger_stream();
        repeat (5) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL grow_stream_left got %0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_reversal();
        do_restart();
        do_tick(DIR_LEFT, 1'b0);
        n_tests++;
        if (snake_head_x !== 7'd41 || snake_head_y !== 7'd30 || self_seen != exp_self) begin
            n_fail++;
            $display("FAIL reversal got (%0d,%0d) sc %0d expected (41,30) sc %0d",
                     snake_head_x, snake_head_y, self_seen, exp_self);
        end
    endtask

    task automatic test_self_collision();
        do_restart();
        for (int i = 0; i < 3; i++) do_tick(DIR_RIGHT, 1'b1);
        n_tests++;
        if (body_if.snake_length !== 4'd5 || snake_head_x !== 7'd43) begin
            n_fail++;
            $display("FAIL loop_setup got len %0d x %0d expected len 5 x 43",
                     body_if.snake_length, snake_head_x);
        end
        do_tick(DIR_UP, 1'b0);
        do_tick(DIR_LEFT, 1'b0);
        do_tick(DIR_DOWN, 1'b0);
        n_tests++;
        if (self_seen != exp_self || exp_self != 1) begin
            n_fail++;
            $display("FAIL self_collision got %0d pulses expected 1 (model %0d)", self_seen, exp_self);
        end
        do_tick(DIR_RIGHT, 1'b0);
        n_tests++;
        if (snake_head_x !== 7'd42 || snake_head_y !== 7'd29 || self_seen != 1) begin
            n_fail++;
            $display("FAIL frozen_head got (%0d,%0d) sc %0d expected (42,29) sc 1",
                     snake_head_x, snake_head_y, self_seen);
        end
        trigger_stream();
        repeat (6) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL frozen_stream_left got %0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_wall();
        do_restart();
        for (int i = 0; i < 39; i++) do_tick(DIR_RIGHT, 1'b0);
        n_tests++;
        if (snake_head_x !== 7'd79) begin
            n_fail++;
            $display("FAIL wall_approach got x %0d expected 79", snake_head_x);
        end
        do_tick(DIR_RIGHT, 1'b0);
`ifdef SNAKE_WRAP_EN
        n_tests++;
        if (snake_head_x !== 7'd0 || wall_seen != 0) begin
            n_fail++;
            $display("FAIL wall_wrap got x %0d wc %0d expected x 0 wc 0", snake_head_x, wall_seen);
        end
`else
        n_tests++;
        if (snake_head_x !== 7'd79 || wall_seen != exp_wall || exp_wall != 1) begin
            n_fail++;
            $display("FAIL wall_hit got x %0d wc %0d expected x 79 wc 1", snake_head_x, wall_seen);
        end
`endif
    endtask

    task automatic test_back_to_back();
        do_restart();
        @(negedge clk);
        push_stream_expect();
        X         = '0;
        Y         = PIX_W'(STREAM_LINE);
        direction = DIR_UP;
        grow      = 1'b1;
        move_tick = 1'b1;
        model_tick(DIR_UP, 1'b1);
        @(negedge clk);
        X         = PIX_W'(1);
        Y         = '0;
        move_tick = 1'b0;
        grow      = 1'b0;
        n_tests++;
        if (body_if.en_snake_body !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_stream_first got en=%b expected 1", body_if.en_snake_body);
        end
        repeat (MAX_LEN + 4) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0 || snake_head_x !== 7'd40 || snake_head_y !== 7'd29 ||
            body_if.snake_length !== 4'd3) begin
            n_fail++;
            $display("FAIL b2b_shift got (%0d,%0d) len %0d left %0d expected (40,29) len 3 left 0",
                     snake_head_x, snake_head_y, body_if.snake_length, exp_q.size());
        end
    endtask

    task automatic test_restart_mid_stream();
        do_restart();
        do_tick(DIR_RIGHT, 1'b1);
        do_tick(DIR_RIGHT, 1'b1);
        trigger_stream();
        game_restart = 1'b1;
        @(negedge clk);
        game_restart = 1'b0;
        n_tests++;
        if (body_if.en_snake_body !== 1'b0 || snake_head_x !== 7'd40 || body_if.snake_length !== 4'd2) begin
            n_fail++;
            $display("FAIL restart_mid_stream got en=%b x %0d len %0d expected en=0 x 40 len 2",
                     body_if.en_snake_body, snake_head_x, body_if.snake_length);
        end
        exp_q.delete();
        model_reset();
    endtask

    task automatic test_async_reset();
        do_tick(DIR_DOWN, 1'b1);
        trigger_stream();
        #5 rst_n = 1'b0;
        #1;
        n_tests++;
        if (body_if.en_snake_body !== 1'b0 || body_if.snake_body_x !== 7'd0) begin
            n_fail++;
            $display("FAIL async_reset got en=%b bx %0d expected en=0 bx 0",
                     body_if.en_snake_body, body_if.snake_body_x);
        end
        exp_q.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (snake_head_x !== 7'd40 || snake_head_y !== 7'd30 || body_if.snake_length !== 4'd2) begin
            n_fail++;
            $display("FAIL async_reset_state got (%0d,%0d) len %0d expected (40,30) len 2",
                     snake_head_x, snake_head_y, body_if.snake_length);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        X            = PIX_W'(1);
        Y            = '0;
        move_tick    = 1'b0;
        grow         = 1'b0;
        game_restart = 1'b0;
        direction    = DIR_RIGHT;
        model_reset();
        #30;
        test_reset();
        #20 rst_n = 1'b1;
        test_first_stream();
        test_grow_up();
        test_reversal();
        test_self_collision();
        test_wall();
        test_back_to_back();
        test_restart_mid_stream();
        test_async_reset();
        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
